parity_byte_feeder: RTL and testbench
=====================================

# parity_byte_feeder

Upstream sequencer for the parity unit. It accepts bytes over a valid/ready stream and launches one parity job per byte with a `start` pulse and stable `data_in`. It tracks the unit's `busy` to completion, captures `even_parity`/`odd_parity`, and emits a 9-bit frame `{parity_bit, byte}` downstream. It also supervises the unit with a watchdog and an inconsistency check, and keeps sticky error flags and a frame counter.

## Interface
- `PARITY_ODD`, default 0: 0 selects an even-parity scheme (`parity_bit = par_odd`); 1 selects an odd-parity scheme (`parity_bit = par_even`).
- `TIMEOUT`, default 63: maximum cycles to wait in either busy-wait state; legal range 1..255.
- `clk` input 1: single clock, all state on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: upstream byte valid.
- `in_data` input 8: upstream byte.
- `in_ready` output 1: feeder can accept a byte.
- `par_start` output 1: one-cycle start pulse to the parity unit.
- `par_data` output 8: byte presented to the parity unit's `data_in`.
- `par_busy` input 1: parity unit `busy`.
- `par_even` input 1: parity unit `even_parity`.
- `par_odd` input 1: parity unit `odd_parity`.
- `out_valid` output 1: frame valid.
- `out_data` output 9: `{parity_bit, byte}`.
- `out_err` output 1: frame flagged inconsistent; qualified by `out_valid`.
- `out_ready` input 1: downstream accepts the frame.
- `timeout_err` output 1: sticky watchdog flag.
- `proto_err` output 1: sticky even/odd inconsistency flag.
- `frame_count` output 16: frames emitted; wraps at 0xFFFF.

## Operation
- **Reset values:** every output is 0, state is IDLE, the latched byte is 0, and the timer is 0.
- **IDLE:** `in_ready = ~par_busy`. When `in_valid & in_ready`, latch `in_data` into `par_data` and go to START.
- **START:** `par_start = 1` for exactly one cycle. Clear the timer and go to WAIT_HI.
- **WAIT_HI:** If `par_busy = 1`, clear the timer and go to WAIT_LO. Otherwise, if timer == TIMEOUT, set `timeout_err` and return to IDLE, dropping the byte. Otherwise increment the timer.
- **WAIT_LO:** If `par_busy = 0`, go to OUTPUT. On that edge:
  - load `out_data = {pbit, par_data}`;
  - load `out_err = (par_even == par_odd)`;
  - set `proto_err` if `out_err`;
  - set `out_valid`.
  
  The timeout rule is the same as in WAIT_HI.
- **OUTPUT:** `out_valid` and `out_data` are held until `out_ready`. On the handshake edge: clear `out_valid`, increment `frame_count`, and go to IDLE.
- `par_data` holds its value from acceptance until the next acceptance and never changes while a job is in flight.
- Sticky flags clear only on reset.
- Frames flagged with `out_err` are still emitted and counted.

## Timing
- The parity unit reacts to `par_start` as follows:
  - it enters its load state on the next edge;
  - `busy` rises one edge later;
  - `busy` stays high for its 8-bit scan, calculate, result and finish cycles;
  - `busy` falls with results stable.
- **Nominal latency:** the acceptance edge is edge 0. `par_start` is high in the cycle after edge 0, and `out_valid` rises on edge 21.
- With `out_ready` held high, throughput is one byte per 23 cycles: OUTPUT handshake, then IDLE accept.
- `in_ready` is 0 in every state except IDLE, so there is no overlap between jobs.
- **Simultaneous events:**
  - `par_busy` rising on the same edge that timer == TIMEOUT counts as success, because the busy check has priority.
  - `out_ready` already high when `out_valid` rises completes the handshake on the next edge.
- **Reset mid-job:** the feeder returns to IDLE, but the parity unit has no reset and may still be busy. IDLE holds `in_ready = 0` until `par_busy = 0`, so it never restarts a running unit.
- **Timer boundary:** the timer holds 8 bits. Exactly TIMEOUT+1 non-busy cycles in WAIT_HI abort the job.

## Structure
- **Shared package `parity_feeder_pkg`:**
  - state enum (IDLE, START, WAIT_HI, WAIT_LO, OUTPUT), 3 bits;
  - `FRAME_W = 9`;
  - `CNT_W = 16`;
  - `TIMER_W = 8`.
- **Sub-module `parity_feeder_timer`:** clear/increment/compare watchdog counter producing `expired`. The FSM, byte register, frame register and counters stay in the top module.

## Test plan
- Bench setup: a behavioural parity-unit model with the timing described above.
- With `PARITY_ODD = 0`, send `in_data = 0xA5` with `out_ready = 1` → `out_data = 9'h0A5`, `out_err = 0`, `out_valid` on edge 21, `frame_count = 1`.
- Send `0x07` (odd popcount) → `out_data = 9'h107`. Repeat with `PARITY_ODD = 1` → `9'h007`.
- Back-to-back `0xFF`, `0x01` with `out_ready` low for 10 cycles on the first frame → `out_data` stable, `in_ready = 0` throughout, both frames in order, `frame_count = 2`.
- Tie `par_busy = 0` with `TIMEOUT = 63` → no `out_valid`, `timeout_err` set 64 cycles after WAIT_HI entry, `in_ready` back to 1.
- Force `par_even = par_odd = 1` at busy fall → frame emitted with `out_err = 1`, `proto_err` sticky after a following clean frame.
- Assert `rst_n = 0` during WAIT_LO while the model stays busy → all outputs 0, `in_ready` stays 0 until `par_busy` falls, then the next byte completes normally.

Source files
------------

// File: rtl/parity_feeder_pkg.sv
// Shared types and widths for the parity unit feeder.
package parity_feeder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_HI,
        WAIT_LO,
        OUTPUT
    } state_t;

    localparam int FRAME_W = 9;
    localparam int CNT_W   = 16;
    localparam int TIMER_W = 8;

endpackage

// File: rtl/parity_feeder_timer.sv
// Watchdog counter for the feeder's busy-wait states.
module parity_feeder_timer
    import parity_feeder_pkg::*;
#(
    parameter logic [TIMER_W-1:0] LIMIT = 8'd63
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (inc)
            count <= count + 1'b1;
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/parity_byte_feeder.sv
// Accepts bytes, launches one parity job per byte, supervises the unit and
// emits {parity_bit, byte} frames with sticky error flags and a frame counter.
module parity_byte_feeder
    import parity_feeder_pkg::*;
#(
    parameter int PARITY_ODD = 0,
    parameter int TIMEOUT    = 63
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               par_start,
    output logic [7:0]         par_data,
    input  logic               par_busy,
    input  logic               par_even,
    input  logic               par_odd,
    output logic               out_valid,
    output logic [FRAME_W-1:0] out_data,
    output logic               out_err,
    input  logic               out_ready,
    output logic               timeout_err,
    output logic               proto_err,
    output logic [CNT_W-1:0]   frame_count
);

    state_t state;
    logic   timer_clear;
    logic   timer_inc;
    logic   timer_expired;
    logic   pbit;
    logic   incons;

    assign pbit   = (PARITY_ODD != 0) ? par_even : par_odd;
    assign incons = (par_even == par_odd);

    // Gated by busy so a unit still running across a feeder reset is never restarted.
    assign in_ready = rst_n & (state == IDLE) & ~par_busy;

    always_comb begin
        timer_clear = 1'b0;
        timer_inc   = 1'b0;
        case (state)
            START:   timer_clear = 1'b1;
            WAIT_HI: begin
                timer_clear = par_busy;
                timer_inc   = ~par_busy;
            end
            WAIT_LO: timer_inc = par_busy;
            default: ;
        endcase
    end

    parity_feeder_timer #(
        .LIMIT(TIMER_W'(TIMEOUT))
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (timer_clear),
        .inc    (timer_inc),
        .expired(timer_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            par_start   <= 1'b0;
            par_data    <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_err     <= 1'b0;
            timeout_err <= 1'b0;
            proto_err   <= 1'b0;
            frame_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && !par_busy) begin
                        par_data  <= in_data;
                        par_start <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    par_start <= 1'b0;
                    state     <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (par_busy) begin
                        state <= WAIT_LO;
                    end else if (timer_expired) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end
                end
                WAIT_LO: begin
                    if (!par_busy) begin
                        out_data  <= {pbit, par_data};
                        out_err   <= incons;
                        out_valid <= 1'b1;
                        if (incons)
                            proto_err <= 1'b1;
                        state <= OUTPUT;
                    end else if (timer_expired) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        frame_count <= frame_count + 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_parity_byte_feeder.sv
// Directed bench for parity_byte_feeder with a behavioural parity-unit model.
module tb_parity_byte_feeder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       par_start;
    logic [7:0] par_data;
    logic       par_busy;
    logic       par_even;
    logic       par_odd;
    logic       out_valid;
    logic [8:0] out_data;
    logic       out_err;
    logic       out_ready;
    logic       timeout_err;
    logic       proto_err;
    logic [15:0] frame_count;

    logic        o_in_ready;
    logic        o_par_start;
    logic [7:0]  o_par_data;
    logic        o_out_valid;
    logic [8:0]  o_out_data;
    logic        o_out_err;
    logic        o_timeout_err;
    logic        o_proto_err;
    logic [15:0] o_frame_count;

    int vectors     = 0;
    int miscompares = 0;
    int exp_count   = 0;

    always #5 clk = ~clk;

    parity_byte_feeder #(.PARITY_ODD(0), .TIMEOUT(63)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .par_start(par_start), .par_data(par_data),
        .par_busy(par_busy), .par_even(par_even), .par_odd(par_odd),
        .out_valid(out_valid), .out_data(out_data), .out_err(out_err),
        .out_ready(out_ready), .timeout_err(timeout_err), .proto_err(proto_err),
        .frame_count(frame_count)
    );

    // Odd-scheme instance shares all stimulus and the same parity-unit model.
    parity_byte_feeder #(.PARITY_ODD(1), .TIMEOUT(63)) u_odd (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(o_in_ready), .par_start(o_par_start), .par_data(o_par_data),
        .par_busy(par_busy), .par_even(par_even), .par_odd(par_odd),
        .out_valid(o_out_valid), .out_data(o_out_data), .out_err(o_out_err),
        .out_ready(out_ready), .timeout_err(o_timeout_err), .proto_err(o_proto_err),
        .frame_count(o_frame_count)
    );

    // Parity unit: load on the edge after start, busy from the next edge for
    // 18 cycles (plus busy_delay extra load cycles), results stable at busy fall.
    logic model_en     = 1'b1;
    logic force_incons = 1'b0;
    int   busy_delay   = 0;
    int   m_cnt        = 0;

    always @(posedge clk) begin
        if (m_cnt == 0) begin
            if (par_start && model_en)
                m_cnt <= 1;
        end else if (m_cnt == 19 + busy_delay) begin
            m_cnt <= 0;
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    assign par_busy = (m_cnt >= 2 + busy_delay);
    assign par_even = force_incons ? 1'b1 : ~(^par_data);
    assign par_odd  = force_incons ? 1'b1 : (^par_data);

    // Presents a byte, waits for acceptance, returns the edge (after acceptance)
    // on which out_valid was first seen, or a negative value.
    task automatic send_byte(input logic [7:0] b, input int max_edges, output int lat);
        lat = -2;
        in_data  = b;
        in_valid = 1'b1;
        for (int k = 0; k < 200 && !in_ready; k++)
            @(negedge clk);
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        lat = -1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int n = 1; n <= max_edges; n++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        vectors++;
        if ({in_ready, par_start, par_data, out_valid, out_data, out_err,
             timeout_err, proto_err, frame_count} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got in_ready=%b start=%b data=%h ov=%b od=%h oe=%b te=%b pe=%b fc=%0d, want all 0",
                     in_ready, par_start, par_data, out_valid, out_data, out_err, timeout_err, proto_err, frame_count);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready: got %b, want 1", in_ready);
        end
    endtask

    task automatic test_even_scheme();
        int lat;
        send_byte(8'hA5, 40, lat);
        vectors++;
        if (lat !== 21) begin miscompares++; $display("FAIL a5_latency: got %0d, want 21", lat); end
        vectors++;
        if (out_data !== 9'h0A5) begin miscompares++; $display("FAIL a5_data: got %h, want 0a5", out_data); end
        vectors++;
        if (out_err !== 1'b0) begin miscompares++; $display("FAIL a5_err: got %b, want 0", out_err); end
        vectors++;
        if (o_out_data !== 9'h1A5) begin miscompares++; $display("FAIL a5_odd_data: got %h, want 1a5", o_out_data); end
        @(negedge clk);
        exp_count++;
        vectors++;
        if (out_valid !== 1'b0 || frame_count !== 16'(exp_count)) begin
            miscompares++;
            $display("FAIL a5_count: got ov=%b fc=%0d, want ov=0 fc=%0d", out_valid, frame_count, exp_count);
        end
    endtask

    task automatic test_odd_popcount();
        int lat;
        send_byte(8'h07, 40, lat);
        vectors++;
        if (lat !== 21 || out_data !== 9'h107) begin
            miscompares++;
            $display("FAIL b07_even_scheme: got lat=%0d data=%h, want lat=21 data=107", lat, out_data);
        end
        vectors++;
        if (o_out_data !== 9'h007) begin miscompares++; $display("FAIL b07_odd_scheme: got %h, want 007", o_out_data); end
        @(negedge clk);
        exp_count++;
        vectors++;
        if (frame_count !== 16'(exp_count)) begin
            miscompares++;
            $display("FAIL b07_count: got %0d, want %0d", frame_count, exp_count);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int bad;
        out_ready = 1'b0;
        send_byte(8'hFF, 40, lat);
        vectors++;
        if (lat !== 21 || out_data !== 9'h0FF) begin
            miscompares++;
            $display("FAIL ff_frame: got lat=%0d data=%h, want lat=21 data=0ff", lat, out_data);
        end
        in_data  = 8'h01;
        in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_data !== 9'h0FF || in_ready !== 1'b0 || par_start !== 1'b0)
                bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL ff_hold: got %0d bad cycles (last ov=%b od=%h rdy=%b), want 0", bad, out_valid, out_data, in_ready);
        end
        out_ready = 1'b1;
        @(negedge clk);
        exp_count++;
        vectors++;
        if (out_valid !== 1'b0 || frame_count !== 16'(exp_count) || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ff_handshake: got ov=%b fc=%0d rdy=%b, want ov=0 fc=%0d rdy=1", out_valid, frame_count, in_ready, exp_count);
        end
        @(negedge clk);
        in_valid = 1'b0;
        vectors++;
        if (par_start !== 1'b1 || par_data !== 8'h01) begin
            miscompares++;
            $display("FAIL b01_accept: got start=%b data=%h, want start=1 data=01", par_start, par_data);
        end
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (out_valid) begin lat = n; break; end
        end
        vectors++;
        if (lat !== 21 || out_data !== 9'h101) begin
            miscompares++;
            $display("FAIL b01_frame: got lat=%0d data=%h, want lat=21 data=101", lat, out_data);
        end
        @(negedge clk);
        exp_count++;
        vectors++;
        if (frame_count !== 16'(exp_count)) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d, want %0d", frame_count, exp_count);
        end
    endtask

    task automatic test_busy_boundary();
        int lat;
        busy_delay = 62;
        send_byte(8'h33, 120, lat);
        vectors++;
        if (lat !== 83 || out_data !== 9'h033) begin
            miscompares++;
            $display("FAIL busy_at_limit: got lat=%0d data=%h, want lat=83 data=033", lat, out_data);
        end
        vectors++;
        if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL busy_at_limit_to: got %b, want 0", timeout_err); end
        @(negedge clk);
        exp_count++;
        busy_delay = 0;
    endtask

    task automatic test_proto();
        int lat;
        force_incons = 1'b1;
        send_byte(8'h3C, 40, lat);
        force_incons = 1'b0;
        vectors++;
        if (lat !== 21 || out_data !== 9'h13C || out_err !== 1'b1) begin
            miscompares++;
            $display("FAIL incons_frame: got lat=%0d data=%h err=%b, want lat=21 data=13c err=1", lat, out_data, out_err);
        end
        vectors++;
        if (proto_err !== 1'b1) begin miscompares++; $display("FAIL incons_flag: got %b, want 1", proto_err); end
        @(negedge clk);
        exp_count++;
        send_byte(8'h81, 40, lat);
        vectors++;
        if (lat !== 21 || out_data !== 9'h081 || out_err !== 1'b0) begin
            miscompares++;
            $display("FAIL clean_after_incons: got lat=%0d data=%h err=%b, want lat=21 data=081 err=0", lat, out_data, out_err);
        end
        @(negedge clk);
        exp_count++;
        vectors++;
        if (proto_err !== 1'b1 || frame_count !== 16'(exp_count)) begin
            miscompares++;
            $display("FAIL proto_sticky: got pe=%b fc=%0d, want pe=1 fc=%0d", proto_err, frame_count, exp_count);
        end
    endtask

    task automatic test_timeout();
        int te_edge;
        int saw_valid;
        model_en = 1'b0;
        te_edge  = -1;
        saw_valid = 0;
        in_data  = 8'h3C;
        in_valid = 1'b1;
        for (int k = 0; k < 200 && !in_ready; k++)
            @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int n = 1; n <= 80; n++) begin
            @(negedge clk);
            if (out_valid) saw_valid++;
            if (timeout_err && te_edge < 0) te_edge = n;
        end
        vectors++;
        if (te_edge !== 65) begin miscompares++; $display("FAIL timeout_edge: got %0d, want 65", te_edge); end
        vectors++;
        if (saw_valid != 0) begin miscompares++; $display("FAIL timeout_no_frame: got %0d valid cycles, want 0", saw_valid); end
        vectors++;
        if (in_ready !== 1'b1 || frame_count !== 16'(exp_count)) begin
            miscompares++;
            $display("FAIL timeout_recover: got rdy=%b fc=%0d, want rdy=1 fc=%0d", in_ready, frame_count, exp_count);
        end
        model_en = 1'b1;
    endtask

    task automatic test_reset_midjob();
        int lat;
        int bad;
        int waited;
        in_data  = 8'h5A;
        in_valid = 1'b1;
        for (int k = 0; k < 200 && !in_ready; k++)
            @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({in_ready, par_start, par_data, out_valid, out_data, out_err,
             timeout_err, proto_err, frame_count} !== '0) begin
            miscompares++;
            $display("FAIL midjob_reset: got rdy=%b start=%b data=%h ov=%b od=%h te=%b pe=%b fc=%0d, want all 0",
                     in_ready, par_start, par_data, out_valid, out_data, timeout_err, proto_err, frame_count);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_count = 0;
        bad = 0;
        waited = 0;
        while (par_busy && waited < 40) begin
            if (in_ready !== 1'b0 || par_start !== 1'b0) bad++;
            @(negedge clk);
            waited++;
        end
        vectors++;
        if (bad != 0 || waited == 0 || waited >= 40) begin
            miscompares++;
            $display("FAIL midjob_hold_ready: got %0d bad cycles over %0d busy cycles, want 0 over 1..39", bad, waited);
        end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL midjob_ready_after: got %b, want 1", in_ready); end
        send_byte(8'h5A, 40, lat);
        vectors++;
        if (lat !== 21 || out_data !== 9'h05A || out_err !== 1'b0) begin
            miscompares++;
            $display("FAIL midjob_next_frame: got lat=%0d data=%h err=%b, want lat=21 data=05a err=0", lat, out_data, out_err);
        end
        @(negedge clk);
        exp_count++;
        vectors++;
        if (frame_count !== 16'(exp_count)) begin
            miscompares++;
            $display("FAIL midjob_count: got %0d, want %0d", frame_count, exp_count);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        test_even_scheme();
        test_odd_popcount();
        test_back_to_back();
        test_busy_boundary();
        test_proto();
        test_timeout();
        test_reset_midjob();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d vectors applied", vectors);
        $fatal(1, "watchdog expired");
    end

endmodule
